grid_pixel_writer: RTL and testbench

//  Pixel-write source for the VGA framebuffer: on a start request, snapshots a GRID_W x GRID_H
//  bit grid and walks every pixel of the scaled grid in raster order. Emits one x/y/pixel_color

---
 rtl/grid_pkg.sv | 22 ++
 rtl/grid_pixel_writer_if.sv | 23 ++
 rtl/pixel_scan_counter.sv | 40 ++++
 rtl/grid_pixel_writer.sv | 140 ++++++++++++++
 tb/tb_grid_pixel_writer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/grid_pkg.sv
// Shared geometry defaults, coordinate type, FSM states and write payload for the grid pixel writer.
package grid_pkg;
  localparam int unsigned GRID_W_DEF    = 40;
  localparam int unsigned GRID_H_DEF    = 10;
  localparam int unsigned CELL_LOG2_DEF = 4;
  localparam int unsigned COORD_W       = 11;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } writer_state_t;

  // One framebuffer write: position and colour
  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   color;
  } pixel_wr_t;
endpackage

// File: rtl/grid_pixel_writer_if.sv
// Control handshake and pixel-write bus between the grid pixel writer (slave) and its user (master).
interface grid_pixel_writer_if;
  import grid_pkg::*;

  logic   start;
  logic   stall;
  coord_t x;
  coord_t y;
  logic   pixel_color;
  logic   pixel_write;
  logic   busy;
  logic   done;

  modport master (
    output start, stall,
    input  x, y, pixel_color, pixel_write, busy, done
  );

  modport slave (
    input  start, stall,
    output x, y, pixel_color, pixel_write, busy, done
  );
endinterface

// File: rtl/pixel_scan_counter.sv
// Raster-order px/py counter over the scaled image; o_last_c flags the final pixel of the frame.
module pixel_scan_counter
  import grid_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 160
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   i_clr,
  input  logic   i_en,
  output coord_t o_px,
  output coord_t o_py,
  output logic   o_last_c
);
  coord_t r_px;
  coord_t r_py;
  logic   w_row_end;

  assign w_row_end = (r_px == COORD_W'(IMG_W - 1));

  // px is the inner index; wrapping it steps py
  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_px <= '0;
      r_py <= '0;
    end else if (i_en) begin
      if (w_row_end) begin
        r_px <= '0;
        r_py <= r_py + COORD_W'(1);
      end else begin
        r_px <= r_px + COORD_W'(1);
      end
    end
  end

  assign o_px     = r_px;
  assign o_py     = r_py;
  assign o_last_c = w_row_end && (r_py == COORD_W'(IMG_H - 1));
endmodule

// File: rtl/grid_pixel_writer.sv
// Snapshots a bit grid on start and streams its scaled image to the framebuffer, one pixel per cycle.
// Build option GRID_PIXEL_WRITER_GRIDLINES_EN blanks the first row/column of every cell (1-px outline).
module grid_pixel_writer
  import grid_pkg::*;
#(
  parameter int unsigned GRID_W    = GRID_W_DEF,
  parameter int unsigned GRID_H    = GRID_H_DEF,
  parameter int unsigned CELL_LOG2 = CELL_LOG2_DEF,
  parameter int unsigned X_ORIGIN  = 0,
  parameter int unsigned Y_ORIGIN  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [GRID_W-1:0] grid_in [GRID_H],
  grid_pixel_writer_if.slave bus
);
  localparam int unsigned CELL  = 32'd1 << CELL_LOG2;
  localparam int unsigned IMG_W = GRID_W * CELL;
  localparam int unsigned IMG_H = GRID_H * CELL;
  localparam int unsigned COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int unsigned ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  writer_state_t     r_state;
  writer_state_t     w_state_d;
  logic [GRID_W-1:0] r_snap [GRID_H];
  pixel_wr_t         r_wr;
  pixel_wr_t         w_wr_d;
  logic              r_write;
  logic              r_busy;
  logic              r_done;
  logic              r_fin;
  logic              w_fin_d;
  logic              w_issue;
  logic              w_snap_load;
  logic              w_scan_clr;
  coord_t            w_px;
  coord_t            w_py;
  logic              w_last_c;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic              w_color;

  // Counter holds the next pixel to issue; parked at (0,0) outside DRAW
  assign w_scan_clr = (r_state != DRAW);

  pixel_scan_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_scan (
    .clock    (clock),
    .reset    (reset),
    .i_clr    (w_scan_clr),
    .i_en     (w_issue),
    .o_px     (w_px),
    .o_py     (w_py),
    .o_last_c (w_last_c)
  );

  assign w_col = COL_W'(w_px >> CELL_LOG2);
  assign w_row = ROW_W'(w_py >> CELL_LOG2);

`ifdef GRID_PIXEL_WRITER_GRIDLINES_EN
  localparam coord_t SUB_MASK = COORD_W'(CELL - 1);
  assign w_color = r_snap[w_row][w_col]
                   && ((w_px & SUB_MASK) != '0)
                   && ((w_py & SUB_MASK) != '0);
`else
  assign w_color = r_snap[w_row][w_col];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // r_fin marks that the last pixel has gone out; DRAW waits one cycle on it so done follows the last write
  always_comb begin
    w_state_d   = r_state;
    w_issue     = 1'b0;
    w_snap_load = 1'b0;
    w_wr_d      = r_wr;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_d   = DRAW;
          w_snap_load = 1'b1;
        end
      end
      DRAW: begin
        if (r_fin) begin
          w_state_d = DONE;
        end else if (!bus.stall) begin
          w_issue = 1'b1;
        end
      end
      DONE: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
    if (w_issue) begin
      w_wr_d.x     = COORD_W'(X_ORIGIN) + w_px;
      w_wr_d.y     = COORD_W'(Y_ORIGIN) + w_py;
      w_wr_d.color = w_color;
    end
    w_fin_d = (w_state_d == DRAW) && (r_fin || (w_issue && w_last_c));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_snap  <= '{default: '0};
      r_wr    <= '0;
      r_write <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      if (w_snap_load) begin
        r_snap <= grid_in;
      end
      r_wr    <= w_wr_d;
      r_write <= w_issue;
      r_busy  <= (w_state_d == DRAW);
      r_done  <= (w_state_d == DONE);
      r_fin   <= w_fin_d;
    end
  end

  assign bus.x           = r_wr.x;
  assign bus.y           = r_wr.y;
  assign bus.pixel_color = r_wr.color;
  assign bus.pixel_write = r_write;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
endmodule

// File: tb/tb_grid_pixel_writer.sv
// Self-checking bench for grid_pixel_writer on a reduced 5x3 grid with 4x4 cells at origin (8,300).
module tb_grid_pixel_writer;
  localparam int unsigned GW    = 5;
  localparam int unsigned GH    = 3;
  localparam int unsigned L     = 2;
  localparam int unsigned CELL  = 4;
  localparam int unsigned X0    = 8;
  localparam int unsigned Y0    = 300;
  localparam int unsigned IMG_W = GW * CELL;
  localparam int unsigned IMG_H = GH * CELL;
  localparam int unsigned IMG_N = IMG_W * IMG_H;
`ifdef GRID_PIXEL_WRITER_GRIDLINES_EN
  localparam bit GL = 1'b1;
`else
  localparam bit GL = 1'b0;
`endif

  typedef struct {
    logic        start;
    logic        stall;
    logic        wr;
    logic [10:0] x;
    logic [10:0] y;
    logic        col;
    logic        busy;
    logic        done;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [GW-1:0] g_grid [GH];
  logic [GW-1:0] snap_m [GH];
  vec_t          tbl [10];
  int            n_vec = 0;
  int            n_err = 0;

  grid_pixel_writer_if bus();

  grid_pixel_writer #(
    .GRID_W    (GW),
    .GRID_H    (GH),
    .CELL_LOG2 (L),
    .X_ORIGIN  (X0),
    .Y_ORIGIN  (Y0)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .grid_in (g_grid),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {x, y, colour, busy} for the k-th write of a frame, from the bench's own snapshot copy
  function automatic logic [23:0] exp_pix(input int k);
    int   px;
    int   py;
    logic c;
    px = k % IMG_W;
    py = k / IMG_W;
    c  = snap_m[py / CELL][px / CELL];
    if (GL && (((px % CELL) == 0) || ((py % CELL) == 0))) c = 1'b0;
    return {11'(X0 + px), 11'(Y0 + py), c, 1'b1};
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({bus.pixel_write, bus.busy, bus.done, bus.x, bus.y, bus.pixel_color});
  endfunction

  task automatic run_frame(input int stall_at, input int stall_len, input int poke_at,
                           input int mutate_at, input int reset_at, input bit hold_start);
    int          n_wr;
    int          stalled;
    bit          stall_d;
    bit          fin;
    bit          quiet;
    logic [10:0] hx;
    logic [10:0] hy;
    n_wr = 0; stalled = 0; stall_d = 1'b0; fin = 1'b0; hx = '0; hy = '0;
    snap_m    = g_grid;
    bus.stall = 1'b0;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = hold_start;
    check("start_busy", 32'({bus.busy, bus.pixel_write, bus.done}), 32'(3'b100));
    for (int cyc = 0; cyc < int'(IMG_N) + 64; cyc++) begin
      @(negedge clock);
      if (stall_d) begin
        check("stall_hold", 32'({bus.pixel_write, bus.x, bus.y, bus.busy}), 32'({1'b0, hx, hy, 1'b1}));
      end else if (bus.done) begin
        fin = 1'b1;
        break;
      end else begin
        check($sformatf("write%0d", n_wr),
              32'({bus.pixel_write, bus.x, bus.y, bus.pixel_color, bus.busy}),
              32'({1'b1, exp_pix(n_wr)}));
        hx = bus.x;
        hy = bus.y;
        n_wr++;
      end
      if (n_wr == reset_at) begin
        reset = 1'b1; bus.stall = 1'b0; bus.start = 1'b0;
        @(negedge clock);
        check("reset_abort", all_outs(), 32'd0);
        reset = 1'b0;
        return;
      end
      bus.start = hold_start || (n_wr == poke_at);
      if (n_wr == stall_at && stalled < stall_len) begin
        bus.stall = 1'b1;
        stalled++;
      end else begin
        bus.stall = 1'b0;
      end
      stall_d = bus.stall;
      if (n_wr == mutate_at) g_grid = '{default: '1};
    end
    check("done_seen", 32'(fin), 32'd1);
    check("write_count", 32'(n_wr), 32'(IMG_N));
    @(negedge clock);
    check("done_single", 32'({bus.done, bus.busy, bus.pixel_write}), 32'd0);
    if (hold_start) begin
      @(negedge clock);
      check("restart_held", 32'({bus.busy, bus.pixel_write}), 32'(2'b10));
      bus.start = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("reset_after_restart", all_outs(), 32'd0);
    end else begin
      quiet = 1'b1;
      repeat (4) begin
        @(negedge clock);
        if (bus.pixel_write || bus.done || bus.busy) quiet = 1'b0;
      end
      check("idle_quiet", 32'(quiet), 32'd1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    // Checkerboard: cell (c,r) lit iff c+r odd
    g_grid[0] = 5'b01010;
    g_grid[1] = 5'b10101;
    g_grid[2] = 5'b01010;

    // start, stall | write, x, y, colour, busy, done
    tbl[0] = '{1'b0, 1'b0, 1'b0, 11'd0,  11'd0,   1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 11'd0,  11'd0,   1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 11'd8,  11'd300, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 11'd9,  11'd300, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 11'd9,  11'd300, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 11'd9,  11'd300, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 11'd10, 11'd300, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 11'd11, 11'd300, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 11'd12, 11'd300, !GL, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 11'd13, 11'd300, !GL, 1'b1, 1'b0};

    repeat (3) @(negedge clock);
    check("reset_outputs", all_outs(), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      bus.start = tbl[i].start;
      bus.stall = tbl[i].stall;
      @(negedge clock);
      check($sformatf("vec%0d", i),
            32'({bus.pixel_write, bus.x, bus.y, bus.pixel_color, bus.busy, bus.done}),
            32'({tbl[i].wr, tbl[i].x, tbl[i].y, tbl[i].col, tbl[i].busy, tbl[i].done}));
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;

    // Reset in the middle of a frame abandons it
    reset = 1'b1;
    @(negedge clock);
    check("reset_mid_draw", all_outs(), 32'd0);
    reset = 1'b0;

    run_frame(-1, 0, -1, -1, -1, 1'b0);
    run_frame(47, 5, 100, -1, -1, 1'b0);

    g_grid[0] = 5'b10110;
    g_grid[1] = 5'b01101;
    g_grid[2] = 5'b11001;
    run_frame(-1, 0, -1, 120, -1, 1'b0);

    g_grid[0] = 5'b00111;
    g_grid[1] = 5'b11000;
    g_grid[2] = 5'b10101;
    run_frame(-1, 0, -1, -1, 60, 1'b0);
    run_frame(13, 2, -1, -1, -1, 1'b0);

    g_grid = '{default: '1};
    run_frame(-1, 0, -1, -1, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
